reg_bank_mp: RTL and testbench

//  Parametrised multi-port ARM register bank; successor of the single-write-port bank.

---
 rtl/reg_bank_pkg.sv | 23 ++
 rtl/reg_scoreboard.sv | 50 +++++
 rtl/reg_bank_mp.sv | 131 +++++++++++++
 tb/tb_reg_bank_mp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the multi-port ARM register bank.
package reg_bank_pkg;

  localparam int unsigned PC_IDX_DEFAULT = 15;

  // Bit positions of N, Z, C, V within the reduced CPSR.
  typedef enum logic [1:0] {
    FlagV = 2'd0,
    FlagC = 2'd1,
    FlagZ = 2'd2,
    FlagN = 2'd3
  } flag_bit_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register plus a registered conflict pulse.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned AW       = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_set_en,
  input  logic [AW-1:0]       i_set_sel,
  input  logic                i_clr_en,
  input  logic [AW-1:0]       i_clr_sel,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic                o_conflict
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_d;
  logic [NUM_REGS-1:0] w_set_hit;
  logic [NUM_REGS-1:0] w_clr_hit;
  logic                r_conflict;
  logic                w_conflict_d;

  always_comb begin
    w_set_hit = '0;
    w_clr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_set_hit[i] = i_set_en && (i_set_sel == AW'(i));
      w_clr_hit[i] = i_clr_en && (i_clr_sel == AW'(i));
    end
    // Set wins over clear so back-to-back loads to one register stay pending.
    w_busy_d     = (r_busy & ~w_clr_hit) | w_set_hit;
    w_conflict_d = |(w_set_hit & r_busy & ~w_clr_hit);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_d;
      r_conflict <= w_conflict_d;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_conflict = r_conflict;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: ALU/load/PC write ports, masked flags, bypassed reads, load scoreboard.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned PC_IDX   = PC_IDX_DEFAULT,
  parameter int unsigned FLAG_W   = 4,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (clog2(NUM_REGS) > 0) ? clog2(NUM_REGS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*AW-1:0]     i_rd_sel,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wa_en,
  input  logic [AW-1:0]            i_wa_sel,
  input  logic [DATA_W-1:0]        i_wa_data,
  input  logic                     i_wb_en,
  input  logic [AW-1:0]            i_wb_sel,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_pc_wr_en,
  input  logic [DATA_W-1:0]        i_pc_wr_data,
  output logic [DATA_W-1:0]        o_pc_data,
  input  logic                     i_flags_wr_en,
  input  logic [FLAG_W-1:0]        i_flags_wr_mask,
  input  logic [FLAG_W-1:0]        i_flags_wr_data,
  output logic [FLAG_W-1:0]        o_flags_data,
  input  logic                     i_sb_set_en,
  input  logic [AW-1:0]            i_sb_set_sel,
  output logic [NUM_REGS-1:0]      o_busy_vec,
  output logic                     o_sb_conflict
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [FLAG_W-1:0]   r_flags;
  logic [NUM_REGS-1:0] w_wa_hit;
  logic [NUM_REGS-1:0] w_wb_hit;
  logic [NUM_REGS-1:0] w_set_hit;
  logic [NUM_REGS-1:0] w_busy;
  logic [AW-1:0]       w_sel [NUM_RD];
  logic [DATA_W-1:0]   w_rd [NUM_RD];
  logic [NUM_RD-1:0]   w_rd_busy;

  // Out-of-range selects match no register: writes drop, reads return 0.
  always_comb begin
    w_wa_hit  = '0;
    w_wb_hit  = '0;
    w_set_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wa_hit[i]  = i_wa_en && (i_wa_sel == AW'(i));
      w_wb_hit[i]  = i_wb_en && (i_wb_sel == AW'(i));
      w_set_hit[i] = i_sb_set_en && (i_sb_set_sel == AW'(i));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wa_hit[i]) begin
          r_regs[i] <= i_wa_data;
        end else if (w_wb_hit[i]) begin
          r_regs[i] <= i_wb_data;
        end else if ((i == int'(PC_IDX)) && i_pc_wr_en) begin
          r_regs[i] <= i_pc_wr_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flags <= '0;
    end else if (i_flags_wr_en) begin
      r_flags <= (r_flags & ~i_flags_wr_mask) | (i_flags_wr_data & i_flags_wr_mask);
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    assign w_sel[p]                        = i_rd_sel[p*AW +: AW];
    assign o_rd_data[p*DATA_W +: DATA_W] = w_rd[p];
  end

  always_comb begin
    w_rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_sel[p] == AW'(i)) begin
          w_rd[p]      = r_regs[i];
          w_rd_busy[p] = w_busy[i];
          if (BYPASS) begin
            if (w_wa_hit[i]) begin
              w_rd[p] = i_wa_data;
            end else if (w_wb_hit[i]) begin
              w_rd[p] = i_wb_data;
            end else if ((i == int'(PC_IDX)) && i_pc_wr_en) begin
              w_rd[p] = i_pc_wr_data;
            end
            // Data arriving this cycle is already bypassed, so no stall is needed.
            if (w_wb_hit[i] && !w_set_hit[i]) w_rd_busy[p] = 1'b0;
          end
        end
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set_en   (i_sb_set_en),
    .i_set_sel  (i_sb_set_sel),
    .i_clr_en   (i_wb_en),
    .i_clr_sel  (i_wb_sel),
    .o_busy_vec (w_busy),
    .o_conflict (o_sb_conflict)
  );

  assign o_rd_busy    = w_rd_busy;
  assign o_pc_data    = r_regs[PC_IDX];
  assign o_flags_data = r_flags;
  assign o_busy_vec   = w_busy;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Scoreboard bench for reg_bank_mp: default bank, a no-bypass bank and a wide 32x64 bank.
module tb_reg_bank_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus for the two 16x32 banks (a: BYPASS=1, b: BYPASS=0).
  logic [11:0] rd_sel;
  logic [95:0] rd_data_a, rd_data_b;
  logic [2:0]  rd_busy_a, rd_busy_b;
  logic        wa_en, wb_en, pc_wr_en, flags_wr_en, sb_set_en;
  logic [3:0]  wa_sel, wb_sel, sb_set_sel;
  logic [31:0] wa_data, wb_data, pc_wr_data, pc_a, pc_b;
  logic [3:0]  flags_mask, flags_wdata, flags_a, flags_b;
  logic [15:0] busy_a, busy_b;
  logic        conf_a, conf_b;

  // Wide bank stimulus.
  logic [19:0]  x_rd_sel;
  logic [255:0] x_rd_data;
  logic [3:0]   x_rd_busy;
  logic         x_wa_en, x_wb_en;
  logic [4:0]   x_wa_sel, x_wb_sel;
  logic [63:0]  x_wa_data, x_wb_data, x_pc;
  logic [3:0]   x_flags;
  logic [31:0]  x_busy;
  logic         x_conf;

  reg_bank_mp u_a (
    .i_clk (clk), .i_reset (reset), .i_rd_sel (rd_sel), .o_rd_data (rd_data_a),
    .o_rd_busy (rd_busy_a), .i_wa_en (wa_en), .i_wa_sel (wa_sel), .i_wa_data (wa_data),
    .i_wb_en (wb_en), .i_wb_sel (wb_sel), .i_wb_data (wb_data), .i_pc_wr_en (pc_wr_en),
    .i_pc_wr_data (pc_wr_data), .o_pc_data (pc_a), .i_flags_wr_en (flags_wr_en),
    .i_flags_wr_mask (flags_mask), .i_flags_wr_data (flags_wdata), .o_flags_data (flags_a),
    .i_sb_set_en (sb_set_en), .i_sb_set_sel (sb_set_sel), .o_busy_vec (busy_a),
    .o_sb_conflict (conf_a)
  );

  reg_bank_mp #(.BYPASS (1'b0)) u_b (
    .i_clk (clk), .i_reset (reset), .i_rd_sel (rd_sel), .o_rd_data (rd_data_b),
    .o_rd_busy (rd_busy_b), .i_wa_en (wa_en), .i_wa_sel (wa_sel), .i_wa_data (wa_data),
    .i_wb_en (wb_en), .i_wb_sel (wb_sel), .i_wb_data (wb_data), .i_pc_wr_en (pc_wr_en),
    .i_pc_wr_data (pc_wr_data), .o_pc_data (pc_b), .i_flags_wr_en (flags_wr_en),
    .i_flags_wr_mask (flags_mask), .i_flags_wr_data (flags_wdata), .o_flags_data (flags_b),
    .i_sb_set_en (sb_set_en), .i_sb_set_sel (sb_set_sel), .o_busy_vec (busy_b),
    .o_sb_conflict (conf_b)
  );

  reg_bank_mp #(.DATA_W (64), .NUM_REGS (32), .NUM_RD (4)) u_w (
    .i_clk (clk), .i_reset (reset), .i_rd_sel (x_rd_sel), .o_rd_data (x_rd_data),
    .o_rd_busy (x_rd_busy), .i_wa_en (x_wa_en), .i_wa_sel (x_wa_sel), .i_wa_data (x_wa_data),
    .i_wb_en (x_wb_en), .i_wb_sel (x_wb_sel), .i_wb_data (x_wb_data), .i_pc_wr_en (1'b0),
    .i_pc_wr_data (64'd0), .o_pc_data (x_pc), .i_flags_wr_en (1'b0),
    .i_flags_wr_mask (4'd0), .i_flags_wr_data (4'd0), .o_flags_data (x_flags),
    .i_sb_set_en (1'b0), .i_sb_set_sel (5'd0), .o_busy_vec (x_busy),
    .o_sb_conflict (x_conf)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [63:0] got);
    if (exp_q.size() == 0) check(tag, got, {64{1'bx}});
    else check(tag, got, exp_q.pop_front());
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; pc_wr_en = 1'b0; flags_wr_en = 1'b0; sb_set_en = 1'b0;
    x_wa_en = 1'b0; x_wb_en = 1'b0;
  endtask

  task automatic sel(input int p, input int v);
    rd_sel[p*4 +: 4] = 4'(v);
  endtask

  function automatic logic [31:0] rda(input int p);
    return rd_data_a[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rdb(input int p);
    return rd_data_b[p*32 +: 32];
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {8'(i), 24'hABCDEF, (32'(i) * 32'h0101_0101) ^ 32'h5A5A_5A5A};
  endfunction

  task automatic wa(input int s, input logic [31:0] d);
    wa_en = 1'b1; wa_sel = 4'(s); wa_data = d;
  endtask

  task automatic wb(input int s, input logic [31:0] d);
    wb_en = 1'b1; wb_sel = 4'(s); wb_data = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd_sel = '0; x_rd_sel = '0;
    wa_sel = '0; wb_sel = '0; wa_data = '0; wb_data = '0; pc_wr_data = '0;
    flags_mask = '0; flags_wdata = '0; sb_set_sel = '0;
    x_wa_sel = '0; x_wb_sel = '0; x_wa_data = '0; x_wb_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    push(0); push(0); push(0); push(0); push(0);
    #2;
    pop_check("rst_rd0", rda(0)); pop_check("rst_flags", flags_a);
    pop_check("rst_busy", busy_a); pop_check("rst_conf", conf_a); pop_check("rst_pc", pc_a);

    // Asynchronous reset mid-cycle
    @(negedge clk); wa(3, 32'h11); sb_set_en = 1'b1; sb_set_sel = 4'd4;
    flags_wr_en = 1'b1; flags_mask = 4'hF; flags_wdata = 4'h6;
    push(32'h11); push(4'h6); push(16'h0010);
    @(negedge clk); idle(); sel(0, 3);
    #2;
    pop_check("pre_rst_r3", rda(0)); pop_check("pre_rst_flags", flags_a);
    pop_check("pre_rst_busy", busy_a);
    #1 reset = 1'b1;
    push(0); push(0); push(0); push(0);
    #1;
    pop_check("arst_r3_a", rda(0)); pop_check("arst_r3_b", rdb(0));
    pop_check("arst_flags", flags_a); pop_check("arst_busy", busy_a);
    reset = 1'b0;
    @(negedge clk); wb(4, 32'h77);
    @(negedge clk); idle(); sel(0, 4);
    push(32'h77); push(0);
    #2;
    pop_check("wb_after_rst_r4", rda(0)); pop_check("wb_after_rst_busy", busy_a);

    // Write priority
    @(negedge clk); wa(5, 32'hAAAA); wb(5, 32'h5555);
    @(negedge clk); idle(); sel(0, 5);
    push(32'hAAAA); push(32'hAAAA);
    #2;
    pop_check("prio_wa_wb_a", rda(0)); pop_check("prio_wa_wb_b", rdb(0));
    @(negedge clk); wa(15, 32'h100); pc_wr_en = 1'b1; pc_wr_data = 32'h204;
    @(negedge clk); idle();
    push(32'h100);
    #2 pop_check("prio_gpr_pc", pc_a);
    @(negedge clk); pc_wr_en = 1'b1; pc_wr_data = 32'h204;
    @(negedge clk); idle();
    push(32'h204);
    #2 pop_check("pc_wr_only", pc_a);
    @(negedge clk); wa(1, 32'h1); wb(2, 32'h2); pc_wr_en = 1'b1; pc_wr_data = 32'h300;
    @(negedge clk); idle(); sel(0, 1); sel(1, 2); sel(2, 15);
    push(32'h1); push(32'h2); push(32'h300); push(32'h300);
    #2;
    pop_check("multi_r1", rda(0)); pop_check("multi_r2", rda(1));
    pop_check("multi_r15", rda(2)); pop_check("multi_pc", pc_a);

    // Bypass vs stored reads
    @(negedge clk); wa(7, 32'h1111);
    @(negedge clk); idle(); wb(7, 32'hCAFE); pc_wr_en = 1'b1; pc_wr_data = 32'h400;
    sel(0, 7); sel(1, 15); sel(2, 14);
    push(32'hCAFE); push(32'h1111); push(32'h400); push(32'h300); push(0); push(0);
    #2;
    pop_check("byp_wb_a", rda(0)); pop_check("nobyp_wb_b", rdb(0));
    pop_check("byp_pc_a", rda(1)); pop_check("nobyp_pc_b", rdb(1));
    pop_check("byp_pc_not_r14_a", rda(2)); pop_check("nobyp_r14_b", rdb(2));
    @(negedge clk); idle();
    push(32'hCAFE); push(32'h400);
    #2;
    pop_check("nobyp_next_b", rdb(0)); pop_check("nobyp_pc_next_b", rdb(1));
    @(negedge clk); wa(7, 32'hBEEF); wb(7, 32'hDEAD);
    push(32'hBEEF); push(32'hCAFE);
    #2;
    pop_check("byp_wa_over_wb_a", rda(0)); pop_check("nobyp_hold_b", rdb(0));

    // Masked flag writes
    @(negedge clk); idle(); flags_wr_en = 1'b1; flags_mask = 4'hF; flags_wdata = 4'hA;
    @(negedge clk); flags_mask = 4'h3; flags_wdata = 4'h5;
    push(4'hA);
    #2 pop_check("flags_full", flags_a);
    @(negedge clk); idle();
    push(4'h9);
    #2 pop_check("flags_masked", flags_a);
    @(negedge clk); flags_wr_en = 1'b1; flags_mask = 4'h0; flags_wdata = 4'hF;
    @(negedge clk); idle();
    push(4'h9); push(4'h9);
    #2;
    pop_check("flags_mask0_a", flags_a); pop_check("flags_mask0_b", flags_b);

    // Scoreboard
    @(negedge clk); sb_set_en = 1'b1; sb_set_sel = 4'd2;
    @(negedge clk); idle(); sel(0, 2);
    push(1); push(16'h0004); push(0);
    #2;
    pop_check("sb_rd_busy", rd_busy_a[0]); pop_check("sb_vec", busy_a);
    pop_check("sb_no_conf", conf_a);
    @(negedge clk); sb_set_en = 1'b1; sb_set_sel = 4'd2;
    @(negedge clk); idle();
    push(1); push(16'h0004);
    #2;
    pop_check("sb_conf_pulse", conf_a); pop_check("sb_still_busy", busy_a);
    @(negedge clk);
    push(0);
    #2 pop_check("sb_conf_ends", conf_a);
    @(negedge clk); wb(2, 32'h21); sb_set_en = 1'b1; sb_set_sel = 4'd2;
    @(negedge clk); idle();
    push(16'h0004);
    #2 pop_check("sb_set_wins", busy_a);
    @(negedge clk); wb(2, 32'h22);
    push(0); push(1);
    #2;
    pop_check("sb_rd_busy_masked_a", rd_busy_a[0]); pop_check("sb_rd_busy_b", rd_busy_b[0]);
    @(negedge clk); idle();
    push(0); push(32'h22);
    #2;
    pop_check("sb_cleared", busy_a); pop_check("sb_wb_data", rda(0));
    @(negedge clk); sb_set_en = 1'b1; sb_set_sel = 4'd3;
    @(negedge clk); idle(); wa(3, 32'h33);
    @(negedge clk); idle();
    push(16'h0008);
    #2 pop_check("sb_wa_no_clear", busy_a);

    // Wide bank: all 32 registers, two writes per cycle on distinct indices
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      x_wa_en = 1'b1; x_wa_sel = 5'(2*i);   x_wa_data = pat(2*i);
      x_wb_en = 1'b1; x_wb_sel = 5'(2*i+1); x_wb_data = pat(2*i+1);
    end
    @(negedge clk); idle();
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        x_rd_sel[p*5 +: 5] = 5'(4*g + p);
        push(pat(4*g + p));
      end
      #2;
      for (int p = 0; p < 4; p++) pop_check($sformatf("wide_r%0d", 4*g + p), x_rd_data[p*64 +: 64]);
    end
    push(pat(15));
    pop_check("wide_pc", x_pc);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
